// File: rtl/reg_writeback_unit.sv
// Write-side front end of the 16x32 register bank: merges ALU results and
// buffered load returns onto the single write port and tracks pending writes.
module reg_writeback_unit #(
  parameter int DATA_W       = 32,
  parameter int IDX_W        = 4,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst_async,
  input  logic                   reserve_en,
  input  logic [IDX_W-1:0]       reserve_index,
  input  logic                   alu_valid,
  input  logic [IDX_W-1:0]       alu_index,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   ld_valid,
  input  logic [IDX_W-1:0]       ld_index,
  input  logic [DATA_W-1:0]      ld_data,
  output logic                   ld_ready,
  output logic                   write_en,
  output logic [IDX_W-1:0]       write_index,
  output logic [DATA_W-1:0]      write,
  output logic [(2**IDX_W)-1:0]  busy
);

  localparam int NUM_REGS = 2 ** IDX_W;
  localparam int PTR_W    = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W    = $clog2(LQ_DEPTH + 1);
  localparam int STV_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LQ_FULL = CNT_W'(LQ_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  logic [IDX_W-1:0]  r_lq_idx  [LQ_DEPTH];
  logic [DATA_W-1:0] r_lq_data [LQ_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve;
  logic              r_write_en;
  logic [IDX_W-1:0]  r_write_index;
  logic [DATA_W-1:0] r_write;
  logic [NUM_REGS-1:0] r_busy;

  logic              w_empty;
  logic              w_starve_max;
  logic              w_alu_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_win_valid;
  logic [IDX_W-1:0]  w_win_idx;
  logic [DATA_W-1:0] w_win_data;

  assign w_empty      = (r_count == '0);
  assign w_starve_max = (r_starve == STV_MAX);

  // Readies are forced low during reset so no handshake can complete then.
  assign ld_ready  = (r_count != LQ_FULL) && !rst_async;
  assign alu_ready = w_alu_ready && !rst_async;
  assign w_push    = ld_valid && ld_ready;

  always_comb begin
    w_alu_ready = 1'b0;
    w_pop       = 1'b0;
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_win_data  = '0;
    if (!w_empty && !(alu_valid && w_starve_max)) begin
      w_pop       = 1'b1;
      w_win_valid = 1'b1;
      w_win_idx   = r_lq_idx[r_rd_ptr];
      w_win_data  = r_lq_data[r_rd_ptr];
    end else begin
      w_alu_ready = 1'b1;
      if (alu_valid) begin
        w_win_valid = 1'b1;
        w_win_idx   = alu_index;
        w_win_data  = alu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lq_idx[r_wr_ptr]  <= ld_index;
      r_lq_data[r_wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      // Only a load win over a waiting ALU result counts as starvation.
      if (w_pop && alu_valid)
        r_starve <= w_starve_max ? r_starve : r_starve + 1'b1;
      else
        r_starve <= '0;
    end
  end

  // Register 0 is hardwired to zero, so a win for index 0 launches nothing.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_write_en    <= 1'b0;
      r_write_index <= '0;
      r_write       <= '0;
    end else begin
      r_write_en <= w_win_valid && (w_win_idx != '0);
      if (w_win_valid && (w_win_idx != '0)) begin
        r_write_index <= w_win_idx;
        r_write       <= w_win_data;
      end
    end
  end

  // A reservation in the same cycle as the clearing write keeps the bit set.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (reserve_en && (reserve_index == IDX_W'(i)))
          r_busy[i] <= 1'b1;
        else if (w_win_valid && (w_win_idx == IDX_W'(i)))
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign write_en    = r_write_en;
  assign write_index = r_write_index;
  assign write       = r_write;
  assign busy        = r_busy;

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
Write-side front end for the 16x32 general register bank. It merges results from the ALU and the load unit into the bank's single write port (write_en / write_index / write), buffers load returns in a small FIFO and arbitrates with bounded ALU starvation. It also keeps a per-register pending scoreboard (busy) that the issue stage reads to stall on read-after-write hazards.

Parameters:
DATA_W, 32, register data width
IDX_W, 4, register index width; NUM_REGS = 2**IDX_W
LQ_DEPTH, 2, load-return FIFO depth (power of two, >=2)
STARVE_LIMIT, 3, consecutive load writes allowed while an ALU result waits

Ports:
clk  input  1  clock, rising edge
rst_async  input  1  asynchronous reset, active high
reserve_en  input  1  issue stage claims a destination register this cycle
reserve_index  input  IDX_W  destination being claimed
alu_valid  input  1  ALU result offered
alu_index  input  IDX_W  ALU destination
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU result accepted when alu_valid && alu_ready
ld_valid  input  1  load return offered
ld_index  input  IDX_W  load destination
ld_data  input  DATA_W  load data
ld_ready  output  1  load accepted when ld_valid && ld_ready
write_en  output  1  to bank write_en (registered)
write_index  output  IDX_W  to bank write_index (registered)
write  output  DATA_W  to bank write data (registered)
busy  output  NUM_REGS  scoreboard; bit i = write to register i pending

Behaviour:
- Reset (async, active high): write_en=0, write_index=0, write=0, busy=0, FIFO emptied (pointers and count 0), starve counter 0. Asserting reset mid-operation discards all queued loads and pending bits. No handshake completes while reset is high.
- ld_ready = FIFO not full (combinational from count). An accepted load is enqueued at the clock edge and cannot be written in the same cycle.
- Arbitration per cycle, with one winner at most:
  - FIFO non-empty and (starve counter < STARVE_LIMIT or !alu_valid): FIFO head wins. alu_ready=0.
  - FIFO non-empty, alu_valid and starve counter == STARVE_LIMIT: ALU wins. alu_ready=1.
  - FIFO empty: alu_ready=1. The ALU wins if alu_valid.
- Starve counter: increments when the head wins while alu_valid=1 (saturates at STARVE_LIMIT). Resets to 0 when the ALU wins or when alu_valid=0.
- Winner is registered: at the edge, write_en=1, write_index=idx and write=data. Next cycle write_en=0 unless there is another winner. Latency from ALU handshake to write_en is 1 cycle. Latency from load handshake to write_en is at least 2 cycles.
- Index 0: the handshake completes and a FIFO pop still occurs, but write_en stays 0 for that slot. This matches register 0 being hardwired to zero.
- FIFO: a simultaneous push and pop when full is not possible, because ld_ready=0 when full. Push and pop in the same cycle when non-full leaves count unchanged. Pointers wrap modulo LQ_DEPTH.
- Scoreboard:
  - busy[i] is set at the edge where reserve_en && reserve_index==i && i!=0.
  - busy[i] clears at the edge where the registered write to i is launched, i.e. when the winner's index is i.
  - If set and clear for the same index happen in the same cycle, set wins.
  - busy[0] is constant 0.
  - Reserving an already-busy register keeps it busy.
- Data for writes arriving out of order to the same register is not reordered. Issue must stall on busy before issuing a second writer.

Test Plan:
- Reset then idle: after rst_async pulse all outputs 0 -> write_en=0, busy=16'h0000, ld_ready=1, alu_ready=1.
- ALU path: reserve r3, next cycle alu_valid idx=3 data=32'h0000_00AA -> busy[3]=1 then cleared at the edge where write_en=1, write_index=3, write=32'hAA one cycle after handshake.
- Load FIFO full: ld_valid held with idx=1,2,3 data=1,2,3 while alu_valid=0 -> writes r1=1, r2=2, r3=3 in order, each on consecutive cycles. ld_ready drops only while 2 entries are held and none popping.
- Starvation bound: FIFO kept non-empty by continuous loads, alu_valid held with idx=5 data=7 -> exactly 3 load writes, then write_index=5 write=7, then loads resume.
- Index 0 and collision: ALU write to r0 -> handshake completes, write_en stays 0. Same-cycle reserve r4 and write launch to r4 -> busy[4]=1 afterwards.
- Reset mid-operation: two loads queued, busy[6]=1, assert rst_async -> FIFO empty, busy=0, no further write_en after release.
